// File: rtl/serv_timer_resp.sv
// RISC-V machine timer (64-bit mtime/mtimecmp) exposed as a Wishbone-style data-bus target.
// Ack arrives WAIT+1 cycles after cyc and never in two consecutive cycles; o_timer_irq is registered.
module serv_timer_resp #(
  parameter int PRESCALE = 1,
  parameter int WAIT     = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_timer_irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int WW = (WAIT > 1) ? $clog2(WAIT) : 1;
  localparam logic [PW-1:0] PS_LAST   = PW'(PRESCALE - 1);
  localparam logic [WW-1:0] WAIT_LOAD = WW'((WAIT > 0) ? WAIT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t          state_q;
  logic [WW-1:0]   wait_q;
  logic            ack_q;
  logic [PW-1:0]   ps_q, ps_d;
  logic [63:0]     mtime_q, mtime_d;
  logic [63:0]     mtimecmp_q, mtimecmp_d;
  logic            irq_q;
  logic            tick;
  logic            wr_en;
  logic [31:0]     rdat;
  logic            unused_adr;

  assign unused_adr = ^i_wb_adr[1:0];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] sel);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = dat[8*b +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_wb_cyc) begin
            if (WAIT > 0) begin
              state_q <= S_WAIT;
              wait_q  <= WAIT_LOAD;
            end else begin
              state_q <= S_ACK;
              ack_q   <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          // A dropped cyc abandons the access before anything is committed.
          if (!i_wb_cyc) begin
            state_q <= S_IDLE;
          end else if (wait_q == '0) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
          end else begin
            wait_q <= wait_q - WW'(1);
          end
        end
        S_ACK:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tick  = (ps_q == PS_LAST);
  assign ps_d  = tick ? '0 : ps_q + PW'(1);
  assign wr_en = ack_q & i_wb_we;

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    // A bus write to either mtime half pre-empts the whole 64-bit increment.
    if (wr_en && !i_wb_adr[3]) begin
      if (i_wb_adr[2]) mtime_d[63:32] = merge(mtime_q[63:32], i_wb_dat, i_wb_sel);
      else             mtime_d[31:0]  = merge(mtime_q[31:0],  i_wb_dat, i_wb_sel);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    if (wr_en && i_wb_adr[3]) begin
      if (i_wb_adr[2]) mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], i_wb_dat, i_wb_sel);
      else             mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0],  i_wb_dat, i_wb_sel);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ps_q       <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
    end else begin
      ps_q       <= ps_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= (mtime_q >= mtimecmp_q);
    end
  end

  always_comb begin
    rdat = '0;
    case (i_wb_adr[3:2])
      2'd0:    rdat = mtime_q[31:0];
      2'd1:    rdat = mtime_q[63:32];
      2'd2:    rdat = mtimecmp_q[31:0];
      default: rdat = mtimecmp_q[63:32];
    endcase
  end

  assign o_wb_rdt    = ack_q ? rdat : 32'd0;
  assign o_wb_ack    = ack_q;
  assign o_timer_irq = irq_q;

endmodule

// File: tb/tb_serv_timer_resp.sv
// Bench for serv_timer_resp: instance A (PRESCALE=1, WAIT=0) and instance B (PRESCALE=4, WAIT=3).
// Stimulus queues the expected response; per-instance monitors pop and compare on each ack.
module tb_serv_timer_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  a_adr, b_adr;
  logic [31:0] a_dat, b_dat;
  logic [3:0]  a_sel, b_sel;
  logic        a_we, b_we, a_cyc, b_cyc;
  logic [31:0] a_rdt, b_rdt;
  logic        a_ack, b_ack, a_irq, b_irq;

  serv_timer_resp #(.PRESCALE(1), .WAIT(0)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(a_adr), .i_wb_dat(a_dat), .i_wb_sel(a_sel),
    .i_wb_we(a_we), .i_wb_cyc(a_cyc), .o_wb_rdt(a_rdt), .o_wb_ack(a_ack), .o_timer_irq(a_irq)
  );

  serv_timer_resp #(.PRESCALE(4), .WAIT(3)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(b_adr), .i_wb_dat(b_dat), .i_wb_sel(b_sel),
    .i_wb_we(b_we), .i_wb_cyc(b_cyc), .o_wb_rdt(b_rdt), .o_wb_ack(b_ack), .o_timer_irq(b_irq)
  );

  typedef struct {
    logic        rd;
    logic [31:0] dat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   checks = 0;
  int   failures = 0;
  int   cyc_n;

  // Rising edges since reset release; mtime of instance A equals this value until it is written.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_n <= 0;
    else        cyc_n <= cyc_n + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pa(input logic rd, input logic [31:0] d);
    exp_t e;
    e.rd = rd; e.dat = d;
    qa.push_back(e);
  endtask

  task automatic pb(input logic rd, input logic [31:0] d);
    exp_t e;
    e.rd = rd; e.dat = d;
    qb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (a_ack) begin
      if (qa.size() == 0) chk("a_unexpected_ack", 64'(a_ack), 64'd0);
      else begin
        ea = qa.pop_front();
        if (ea.rd) chk("a_rdata", 64'(a_rdt), 64'(ea.dat));
      end
    end else if (rst_n) begin
      chk("a_rdt_idle", 64'(a_rdt), 64'd0);
    end
  end

  always @(negedge clk) begin
    if (b_ack) begin
      if (qb.size() == 0) chk("b_unexpected_ack", 64'(b_ack), 64'd0);
      else begin
        eb = qb.pop_front();
        if (eb.rd) chk("b_rdata", 64'(b_rdt), 64'(eb.dat));
      end
    end else if (rst_n) begin
      chk("b_rdt_idle", 64'(b_rdt), 64'd0);
    end
  end

  // Called just after a rising edge; returns just after the edge that ends the ACK cycle.
  task automatic a_xfer(input logic [3:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] exp);
    bit seen = 1'b0;
    pa(!we, exp);
    a_adr = adr; a_we = we; a_dat = dat; a_sel = sel; a_cyc = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = a_ack;
    end
    if (!seen) chk("a_ack_timeout", 64'(seen), 64'd1);
    @(posedge clk); #1;
    a_cyc = 1'b0;
  endtask

  task automatic b_xfer(input logic [3:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] exp);
    bit seen = 1'b0;
    pb(!we, exp);
    b_adr = adr; b_we = we; b_dat = dat; b_sel = sel; b_cyc = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = b_ack;
    end
    if (!seen) chk("b_ack_timeout", 64'(seen), 64'd1);
    @(posedge clk); #1;
    b_cyc = 1'b0;
  endtask

  initial begin
    logic [4:0] a_pat;
    logic [5:0] b_pat;
    a_pat = 5'b01010;
    b_pat = 6'b010000;
    rst_n = 1'b0;
    a_adr = '0; a_dat = '0; a_sel = '0; a_we = 1'b0; a_cyc = 1'b0;
    b_adr = '0; b_dat = '0; b_sel = '0; b_we = 1'b0; b_cyc = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_ack", 64'(a_ack), 64'd0);
    chk("rst_a_irq", 64'(a_irq), 64'd0);
    chk("rst_b_rdt", 64'(b_rdt), 64'd0);
    rst_n = 1'b1;

    fork
      begin : branch_a
        @(posedge clk); #1;
        a_xfer(4'h0, 1'b0, '0, 4'hF, 32'(cyc_n + 1));
        a_xfer(4'h4, 1'b0, '0, 4'hF, 32'h0);
        a_xfer(4'h8, 1'b0, '0, 4'hF, 32'hFFFF_FFFF);
        a_xfer(4'hC, 1'b0, '0, 4'h0, 32'hFFFF_FFFF);
        chk("a_irq_idle", 64'(a_irq), 64'd0);
        a_xfer(4'h1, 1'b0, '0, 4'hF, 32'(cyc_n + 1));
        // cyc held high: ack on the 2nd and 4th observed cycles only.
        pa(1'b1, 32'hFFFF_FFFF);
        pa(1'b1, 32'hFFFF_FFFF);
        a_adr = 4'h8; a_we = 1'b0; a_cyc = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk($sformatf("a_latency_c%0d", i), 64'(a_ack), 64'(a_pat[i]));
        end
        #1 a_cyc = 1'b0;
        @(posedge clk); #1;
        a_xfer(4'h0, 1'b1, 32'h0000_0004, 4'hF, '0);
        a_xfer(4'h0, 1'b1, 32'hAABB_CCDD, 4'b0010, '0);
        a_xfer(4'h0, 1'b0, '0, 4'hF, 32'h0000_CC06);
        a_xfer(4'h4, 1'b0, '0, 4'hF, 32'h0);
        a_xfer(4'h4, 1'b1, 32'hFFFF_FFFF, 4'hF, '0);
        a_xfer(4'h0, 1'b1, 32'hFFFF_FFFF, 4'hF, '0);
        fork
          begin
            a_xfer(4'h0, 1'b0, '0, 4'hF, 32'h0);
            a_xfer(4'h4, 1'b0, '0, 4'hF, 32'h0);
          end
          begin
            @(negedge clk); chk("a_wrap_irq0", 64'(a_irq), 64'd0);
            @(negedge clk); chk("a_wrap_irq1", 64'(a_irq), 64'd1);
            @(negedge clk); chk("a_wrap_irq2", 64'(a_irq), 64'd0);
          end
        join
      end
      begin : branch_b
        @(posedge clk); #1;
        b_xfer(4'h8, 1'b1, 32'h0000_0010, 4'hF, '0);
        b_xfer(4'hC, 1'b1, 32'h0000_0000, 4'hF, '0);
        pb(1'b1, 32'h0000_0010);
        b_adr = 4'h8; b_we = 1'b0; b_cyc = 1'b1;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          chk($sformatf("b_latency_c%0d", i), 64'(b_ack), 64'(b_pat[i]));
        end
        #1 b_cyc = 1'b0;
        @(posedge clk); #1;
        b_xfer(4'hC, 1'b0, '0, 4'hF, 32'h0);
        for (int i = 0; i < 200 && cyc_n != 64; i++) @(negedge clk);
        chk("b_reach_cycle64", 64'(cyc_n), 64'd64);
        chk("b_irq_before", 64'(b_irq), 64'd0);
        @(negedge clk);
        chk("b_irq_rise", 64'(b_irq), 64'd1);
        @(posedge clk); #1;
        b_xfer(4'hC, 1'b1, 32'h0000_0001, 4'hF, '0);
        @(negedge clk); chk("b_irq_hold", 64'(b_irq), 64'd1);
        @(negedge clk); chk("b_irq_clear", 64'(b_irq), 64'd0);
        @(posedge clk); #1;
        b_xfer(4'h0, 1'b0, '0, 4'hF, 32'((cyc_n + 4) / 4));
        b_adr = 4'h8; b_we = 1'b1; b_dat = 32'hDEAD_BEEF; b_sel = 4'hF; b_cyc = 1'b1;
        @(negedge clk); chk("b_abort_c0", 64'(b_ack), 64'd0);
        @(negedge clk); chk("b_abort_c1", 64'(b_ack), 64'd0);
        #1 b_cyc = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk($sformatf("b_abort_idle%0d", i), 64'(b_ack), 64'd0);
        end
        @(posedge clk); #1;
        b_xfer(4'h8, 1'b0, '0, 4'hF, 32'h0000_0010);
        b_xfer(4'hC, 1'b0, '0, 4'hF, 32'h0000_0001);
      end
    join

    @(posedge clk); #1;
    pa(1'b0, '0);
    a_adr = 4'h8; a_we = 1'b1; a_dat = 32'h1234_5678; a_sel = 4'hF; a_cyc = 1'b1;
    @(negedge clk); chk("rst_mid_pre", 64'(a_ack), 64'd0);
    @(negedge clk); chk("rst_mid_ack", 64'(a_ack), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_ack_drop", 64'(a_ack), 64'd0);
    a_cyc = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    a_xfer(4'h8, 1'b0, '0, 4'hF, 32'hFFFF_FFFF);
    a_xfer(4'h0, 1'b0, '0, 4'hF, 32'(cyc_n + 1));
    chk("rst_a_irq_after", 64'(a_irq), 64'd0);
    b_xfer(4'h8, 1'b0, '0, 4'hF, 32'hFFFF_FFFF);
    b_xfer(4'hC, 1'b0, '0, 4'hF, 32'hFFFF_FFFF);
    chk("rst_b_irq_after", 64'(b_irq), 64'd0);
    repeat (3) @(negedge clk);
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
